// File: rtl/inst_enc_pkg.sv
// inst_enc_pkg
// Shared definitions for the instruction encoder in the program-loader path.
// Holds the field-bundle kind codes, the RV32I major opcodes (the same values
// the CPU's main control decoder matches), the encoder state type and the
// kind-to-opcode mapping.
// Optional feature macro used by the encoder: INST_ENCODER_LI_EN.
package inst_enc_pkg;

    // Field-bundle kind codes; 10..15 are unsupported.
    localparam logic [3:0] KIND_LW     = 4'd0;
    localparam logic [3:0] KIND_SW     = 4'd1;
    localparam logic [3:0] KIND_OPIMM  = 4'd2;
    localparam logic [3:0] KIND_BRANCH = 4'd3;
    localparam logic [3:0] KIND_JAL    = 4'd4;
    localparam logic [3:0] KIND_LUI    = 4'd5;
    localparam logic [3:0] KIND_OP     = 4'd6;
    localparam logic [3:0] KIND_AUIPC  = 4'd7;
    localparam logic [3:0] KIND_JALR   = 4'd8;
    localparam logic [3:0] KIND_LI     = 4'd9;

    // RV32I major opcodes.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Encoder control states; EMIT2 only exists when LI expansion is built.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_EMIT2 = 1'b1
    } enc_state_t;

    // Maps a kind code to its major opcode. A zero result marks a kind that
    // has no direct single-word encoding (LI and the unsupported codes).
    function automatic logic [6:0] kind_to_opcode(input logic [3:0] kind);
        logic [6:0] opc;
        case (kind)
            KIND_LW:     opc = OPC_LOAD;
            KIND_SW:     opc = OPC_STORE;
            KIND_OPIMM:  opc = OPC_OPIMM;
            KIND_BRANCH: opc = OPC_BRANCH;
            KIND_JAL:    opc = OPC_JAL;
            KIND_LUI:    opc = OPC_LUI;
            KIND_OP:     opc = OPC_OP;
            KIND_AUIPC:  opc = OPC_AUIPC;
            KIND_JALR:   opc = OPC_JALR;
            default:     opc = 7'd0;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/inst_encoder_imm_packer.sv
// imm_packer
// Combinational immediate placement for the instruction encoder. Returns the
// instruction bits contributed by the immediate (and funct7_5 where it lives in
// bit 30); opcode, registers and funct3 are merged by the top level.
// Ports:
//   kind      in   4   field-bundle kind code
//   funct3    in   3   funct3, selects the shift form of OPIMM
//   funct7_5  in   1   value for instruction bit 30 (OP, OPIMM SRLI/SRAI)
//   imm       in  32   immediate / offset / upper value
//   imm_bits  out 32   placed immediate bits, zero elsewhere
//   range_err out  1   BRANCH/JAL offset does not fit its field
module imm_packer
    import inst_enc_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_err
);

    // Places the immediate per instruction format. Bit 0 of branch and jump
    // offsets is dropped because targets are always halfword aligned; the
    // range checks require the upper bits to be a pure sign extension of the
    // field's top bit. SLLI keeps bit 30 clear, only SRLI/SRAI carry funct7_5.
    always_comb begin
        imm_bits  = '0;
        range_err = 1'b0;
        case (kind)
            KIND_LW, KIND_JALR: begin
                imm_bits = {imm[11:0], 20'd0};
            end
            KIND_OPIMM: begin
                if (funct3 == 3'b001) begin
                    imm_bits = {7'd0, imm[4:0], 20'd0};
                end else if (funct3 == 3'b101) begin
                    imm_bits = {1'b0, funct7_5, 5'd0, imm[4:0], 20'd0};
                end else begin
                    imm_bits = {imm[11:0], 20'd0};
                end
            end
            KIND_SW: begin
                imm_bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
            end
            KIND_BRANCH: begin
                imm_bits  = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
                range_err = (imm[31:12] != {20{imm[12]}});
            end
            KIND_JAL: begin
                imm_bits  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
                range_err = (imm[31:20] != {12{imm[20]}});
            end
            KIND_LUI, KIND_AUIPC: begin
                imm_bits = {imm[31:12], 12'd0};
            end
            KIND_OP: begin
                imm_bits = {1'b0, funct7_5, 30'd0};
            end
            default: begin
                imm_bits  = '0;
                range_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder
// Encodes field-level instruction descriptions into packed RV32I words for the
// IMEM write port, tagging each word with a sequential word address.
// Optional LI pseudo-instruction expansion is built when the macro
// INST_ENCODER_LI_EN is defined; otherwise kind 9 is treated as unsupported.
// Ports:
//   clk          in   1       clock, rising edge
//   rstn         in   1       synchronous active-low reset
//   clear        in   1       synchronous restart of address, err and state
//   in_valid     in   1       field bundle valid
//   in_ready     out  1       bundle accepted on in_valid & in_ready
//   in_kind      in   4       kind code
//   in_funct3    in   3       funct3 field
//   in_funct7_5  in   1       instruction bit 30 for OP / OPIMM 101
//   in_rd        in   5       destination register
//   in_rs1       in   5       source register 1
//   in_rs2       in   5       source register 2
//   in_imm       in  32       immediate / offset / upper value
//   out_valid    out  1       encoded word valid
//   out_ready    in   1       downstream accept
//   out_inst     out 32       encoded instruction
//   out_addr     out ADDR_W   word address of out_inst
//   err          out  1       sticky error flag
module inst_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7_5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    import inst_enc_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [31:0] imm_bits;
    logic        range_err;
    logic [6:0]  opcode;
    logic [31:0] reg_bits;
    logic [31:0] main_word;
    logic [31:0] first_word;
    logic        drop;
    logic        idle_now;
    logic        accept;
    logic        out_fire;

    imm_packer u_imm_packer (
        .kind      (in_kind),
        .funct3    (in_funct3),
        .funct7_5  (in_funct7_5),
        .imm       (in_imm),
        .imm_bits  (imm_bits),
        .range_err (range_err)
    );

    assign opcode = kind_to_opcode(in_kind);

    // Register and funct3 fields per instruction format; U/J formats carry
    // no funct3 so the supplied value is ignored for them.
    always_comb begin
        reg_bits = '0;
        case (in_kind)
            KIND_LW, KIND_OPIMM, KIND_JALR: begin
                reg_bits = {12'd0, in_rs1, in_funct3, in_rd, 7'd0};
            end
            KIND_SW, KIND_BRANCH: begin
                reg_bits = {7'd0, in_rs2, in_rs1, in_funct3, 5'd0, 7'd0};
            end
            KIND_JAL, KIND_LUI, KIND_AUIPC: begin
                reg_bits = {20'd0, in_rd, 7'd0};
            end
            KIND_OP: begin
                reg_bits = {7'd0, in_rs2, in_rs1, in_funct3, in_rd, 7'd0};
            end
            default: begin
                reg_bits = '0;
            end
        endcase
    end

    assign main_word = imm_bits | reg_bits | {25'd0, opcode};

`ifdef INST_ENCODER_LI_EN
    enc_state_t  state;
    logic [31:0] pending_word;
    logic [31:0] second_word;
    logic        second_pending;
    logic [19:0] li_upper;
    logic        li_short;

    assign idle_now = (state == ST_IDLE);

    // LI selection. The LUI upper part is rounded by imm[11] because the
    // following ADDI sign-extends its 12-bit immediate. A zero low part makes
    // the ADDI a no-op, so only the LUI is emitted.
    always_comb begin
        li_upper       = in_imm[31:12] + {19'd0, in_imm[11]};
        li_short       = (in_imm[31:11] == {21{in_imm[11]}});
        first_word     = main_word;
        second_word    = '0;
        second_pending = 1'b0;
        drop           = (opcode == 7'd0) || range_err;
        if (in_kind == KIND_LI) begin
            drop = 1'b0;
            if (li_short) begin
                first_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_OPIMM};
            end else begin
                first_word     = {li_upper, in_rd, OPC_LUI};
                second_word    = {in_imm[11:0], in_rd, 3'b000, in_rd, OPC_OPIMM};
                second_pending = (in_imm[11:0] != 12'd0);
            end
        end
    end
`else
    assign idle_now = 1'b1;

    // Without LI expansion every bundle maps to at most one word.
    always_comb begin
        first_word = main_word;
        drop       = (opcode == 7'd0) || range_err;
    end
`endif

    assign in_ready = rstn & ~clear & idle_now & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Output register, address counter and (optionally) the LI state machine.
    // A handshake retires the current word first; a same-cycle accept then
    // reloads the register, giving back-to-back throughput. Dropped bundles
    // only raise err. clear outranks both accept and handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid    <= 1'b0;
            out_inst     <= '0;
            out_addr     <= BASE_ADDR;
            err          <= 1'b0;
`ifdef INST_ENCODER_LI_EN
            state        <= ST_IDLE;
            pending_word <= '0;
`endif
        end else if (clear) begin
            out_valid <= 1'b0;
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
`ifdef INST_ENCODER_LI_EN
            state     <= ST_IDLE;
`endif
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
                out_addr  <= out_addr + ADDR_ONE;
                if (out_addr == ADDR_MAX) begin
                    err <= 1'b1;
                end
            end
`ifdef INST_ENCODER_LI_EN
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (drop) begin
                            err <= 1'b1;
                        end else begin
                            out_valid <= 1'b1;
                            out_inst  <= first_word;
                            if (second_pending) begin
                                pending_word <= second_word;
                                state        <= ST_EMIT2;
                            end
                        end
                    end
                end
                ST_EMIT2: begin
                    if (out_fire) begin
                        out_valid <= 1'b1;
                        out_inst  <= pending_word;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
`else
            if (accept) begin
                if (drop) begin
                    err <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_inst  <= first_word;
                end
            end
`endif
        end
    end

endmodule
